// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: FSM states,
// default vectors and the target alignment test.
package pc_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_t;

    localparam int unsigned DEFAULT_XLEN         = 32;
    localparam int unsigned DEFAULT_CNT_W        = 16;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

    // Instruction fetch targets must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: sequential advance, trap/branch/jump redirects
// with a pending slot that holds a redirect requested while fetch is stalled.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     CNT_W        = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_target,
    input  logic             branch_valid,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             jump_valid,
    input  logic [XLEN-1:0]  jump_target,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             redirect_pending,
    output logic             misaligned,
    output logic [XLEN-1:0]  bad_addr,
    output logic [CNT_W-1:0] redirect_cnt
);

    pc_state_t       state, state_next;
    logic [XLEN-1:0] pending_target, pending_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] bad_addr_next;
    logic            misaligned_next;
    logic            redirect_inc;

    logic            req_valid;
    logic [XLEN-1:0] req_target;
    logic [XLEN-1:0] apply_target;
    logic            apply_redirect;

    assign pc_plus4         = pc + XLEN'(4);
    assign redirect_pending = (state == PEND);

    // Branch outranks jump; the loser of a same-cycle pair is dropped.
    assign req_valid  = branch_valid | jump_valid;
    assign req_target = branch_valid ? branch_target : jump_target;

    always_comb begin
        state_next      = state;
        pending_next    = pending_target;
        pc_next         = pc;
        bad_addr_next   = bad_addr;
        misaligned_next = 1'b0;
        redirect_inc    = 1'b0;
        apply_redirect  = 1'b0;
        apply_target    = req_target;

        if (trap_valid) begin
            pc_next      = trap_target;
            pending_next = '0;
            state_next   = RUN;
            redirect_inc = 1'b1;
        end else if (req_valid) begin
            if (stall) begin
                // Newest request overwrites any older pending target.
                pending_next = req_target;
                state_next   = PEND;
            end else begin
                apply_redirect = 1'b1;
                apply_target   = req_target;
            end
        end else if (state == PEND) begin
            if (!stall) begin
                apply_redirect = 1'b1;
                apply_target   = pending_target;
            end
        end else if (!stall) begin
            pc_next = pc_plus4;
        end

        // Alignment is checked when a target is actually loaded into pc.
        if (apply_redirect) begin
            state_next   = RUN;
            redirect_inc = 1'b1;
            if (is_misaligned(apply_target[1:0])) begin
                pc_next         = TRAP_VECTOR;
                misaligned_next = 1'b1;
                bad_addr_next   = apply_target;
            end else begin
                pc_next = apply_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_VECTOR;
            pending_target <= '0;
            misaligned     <= 1'b0;
            bad_addr       <= '0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            pending_target <= pending_next;
            misaligned     <= misaligned_next;
            bad_addr       <= bad_addr_next;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_inc),
        .count (redirect_cnt)
    );

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen, plus a narrow-counter instance
// sharing the same stimulus to observe saturation.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic        trap_valid, branch_valid, jump_valid;
    logic [31:0] trap_target, branch_target, jump_target;

    logic [31:0] pc, pc_plus4, bad_addr;
    logic        redirect_pending, misaligned;
    logic [15:0] redirect_cnt;

    logic [31:0] pc_s, pc_plus4_s, bad_addr_s;
    logic        redirect_pending_s, misaligned_s;
    logic [1:0]  redirect_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .pc(pc), .pc_plus4(pc_plus4), .redirect_pending(redirect_pending),
        .misaligned(misaligned), .bad_addr(bad_addr), .redirect_cnt(redirect_cnt)
    );

    pc_gen #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .stall(stall),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .pc(pc_s), .pc_plus4(pc_plus4_s), .redirect_pending(redirect_pending_s),
        .misaligned(misaligned_s), .bad_addr(bad_addr_s), .redirect_cnt(redirect_cnt_s)
    );

    typedef struct {
        logic        rst, stl, tv, bv, jv;
        logic [31:0] tt, bt, jt;
        logic [31:0] e_pc;
        logic        e_pend, e_mis;
        logic [31:0] e_bad;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, stl, tv, input logic [31:0] tt,
                       input logic bv, input logic [31:0] bt,
                       input logic jv, input logic [31:0] jt,
                       input logic [31:0] e_pc, input logic e_pend, e_mis,
                       input logic [31:0] e_bad, input int e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.tv = tv; v.tt = tt; v.bv = bv; v.bt = bt;
        v.jv = jv; v.jt = jt; v.e_pc = e_pc; v.e_pend = e_pend; v.e_mis = e_mis;
        v.e_bad = e_bad; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; stall = v.stl;
        trap_valid = v.tv; trap_target = v.tt;
        branch_valid = v.bv; branch_target = v.bt;
        jump_valid = v.jv; jump_target = v.jt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input vec_t v);
        string tag;
        int    sat;
        tag = $sformatf("v%0d", idx);
        sat = (v.e_cnt > 3) ? 3 : v.e_cnt;
        check({tag, ".pc"},        pc, v.e_pc);
        check({tag, ".pc_plus4"},  pc_plus4, v.e_pc + 32'd4);
        check({tag, ".pending"},   {31'd0, redirect_pending}, {31'd0, v.e_pend});
        check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, v.e_mis});
        check({tag, ".bad_addr"},  bad_addr, v.e_bad);
        check({tag, ".cnt"},       {16'd0, redirect_cnt}, v.e_cnt);
        check({tag, ".cnt_sat"},   {30'd0, redirect_cnt_s}, sat);
        check({tag, ".pc_small"},  pc_s, v.e_pc);
    endtask

    initial begin
        vec_t h;
        reset = 1'b1; stall = 1'b0;
        trap_valid = 1'b0; branch_valid = 1'b0; jump_valid = 1'b0;
        trap_target = '0; branch_target = '0; jump_target = '0;

        //   rst stl tv tt       bv bt       jv jt       pc       pend mis bad      cnt
        add(1, 0, 0, 0,       0, 0,       0, 0,       32'h000, 0, 0, 32'h000, 0);
        add(1, 0, 0, 0,       0, 0,       0, 0,       32'h000, 0, 0, 32'h000, 0);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h004, 0, 0, 32'h000, 0);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h008, 0, 0, 32'h000, 0);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h00C, 0, 0, 32'h000, 0);
        add(0, 1, 0, 0,       1, 32'h100, 0, 0,       32'h00C, 1, 0, 32'h000, 0);
        add(0, 1, 0, 0,       0, 0,       0, 0,       32'h00C, 1, 0, 32'h000, 0);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h100, 0, 0, 32'h000, 1);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h104, 0, 0, 32'h000, 1);
        add(0, 1, 0, 0,       1, 32'h100, 0, 0,       32'h104, 1, 0, 32'h000, 1);
        add(0, 1, 0, 0,       0, 0,       1, 32'h200, 32'h104, 1, 0, 32'h000, 1);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h200, 0, 0, 32'h000, 2);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h204, 0, 0, 32'h000, 2);
        add(0, 1, 1, 32'h40,  1, 32'h300, 0, 0,       32'h040, 0, 0, 32'h000, 3);
        add(0, 1, 0, 0,       1, 32'h300, 0, 0,       32'h040, 1, 0, 32'h000, 3);
        add(0, 1, 1, 32'h50,  0, 0,       0, 0,       32'h050, 0, 0, 32'h000, 4);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h054, 0, 0, 32'h000, 4);
        add(0, 0, 0, 0,       0, 0,       1, 32'h102, 32'h080, 0, 1, 32'h102, 5);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h084, 0, 0, 32'h102, 5);
        add(0, 1, 0, 0,       1, 32'h202, 0, 0,       32'h084, 1, 0, 32'h102, 5);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h080, 0, 1, 32'h202, 6);
        add(0, 0, 0, 0,       0, 0,       0, 0,       32'h084, 0, 0, 32'h202, 6);
        add(0, 1, 0, 0,       1, 32'h300, 0, 0,       32'h084, 1, 0, 32'h202, 6);
        add(0, 0, 0, 0,       0, 0,       1, 32'h400, 32'h400, 0, 0, 32'h202, 7);
        add(0, 0, 1, 32'h10,  1, 32'h500, 1, 32'h604, 32'h010, 0, 0, 32'h202, 8);
        add(0, 0, 0, 0,       1, 32'h600, 1, 32'h700, 32'h600, 0, 0, 32'h202, 9);
        add(0, 1, 0, 0,       0, 0,       0, 0,       32'h600, 0, 0, 32'h202, 9);
        add(0, 0, 1, 32'h43,  0, 0,       0, 0,       32'h043, 0, 0, 32'h202, 10);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check_all(i, vecs[i]);
        end

        // Reset wins over a trap while a redirect is pending; pending is discarded.
        h = vecs[0];
        h.rst = 0; h.stl = 1; h.bv = 1; h.bt = 32'h300;
        apply(h);
        check("rst_pend.pending", {31'd0, redirect_pending}, 32'd1);
        h.rst = 1; h.tv = 1; h.tt = 32'h70; h.jv = 1; h.jt = 32'h800;
        apply(h);
        check("rst_pend.pc", pc, 32'h0);
        check("rst_pend.pending0", {31'd0, redirect_pending}, 32'd0);
        check("rst_pend.cnt", {16'd0, redirect_cnt}, 32'd0);
        check("rst_pend.bad", bad_addr, 32'h0);
        h = vecs[0];
        h.rst = 0;
        apply(h);
        check("rst_rel.pc", pc, 32'h4);
        check("rst_rel.pending", {31'd0, redirect_pending}, 32'd0);

        // pc_plus4 wraps at the top of the address space.
        h.tv = 1; h.tt = 32'hFFFF_FFFC;
        apply(h);
        check("wrap.pc", pc, 32'hFFFF_FFFC);
        check("wrap.pc_plus4", pc_plus4, 32'h0);
        h.tv = 0;
        apply(h);
        check("wrap.next_pc", pc, 32'h0);
        check("wrap.cnt_sat", {30'd0, redirect_cnt_s}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, program-counter and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded during reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0080, PC value loaded on a misaligned redirect.
REQ-004 SHALL have parameter CNT_W, default 16, width of the redirect counter.
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port stall  input  1  fetch hold; PC must not advance sequentially while high.
REQ-008 SHALL have port trap_valid  input  1  exception redirect request.
REQ-009 SHALL have port trap_target  input  XLEN  exception handler address.
REQ-010 SHALL have port branch_valid  input  1  taken-branch redirect request.
REQ-011 SHALL have port branch_target  input  XLEN  branch destination.
REQ-012 SHALL have port jump_valid  input  1  jump redirect request.
REQ-013 SHALL have port jump_target  input  XLEN  jump destination.
REQ-014 SHALL have port pc  output  XLEN  current fetch address (registered).
REQ-015 SHALL have port pc_plus4  output  XLEN  pc + 4, combinational, wraps modulo 2^XLEN.
REQ-016 SHALL have port redirect_pending  output  1  high while in state PEND.
REQ-017 SHALL have port misaligned  output  1  one-cycle pulse, registered, on a rejected target.
REQ-018 SHALL have port bad_addr  output  XLEN  last rejected target; holds until the next rejection.
REQ-019 SHALL have port redirect_cnt  output  CNT_W  count of applied redirects, saturating.

Function
REQ-020 SHALL select the redirect source by priority trap > branch > jump; lower-priority requests in the same cycle are dropped.
REQ-021 SHALL load trap_target into pc on the next edge regardless of stall, clear any pending target, and enter RUN.
REQ-022 SHALL load the branch/jump target into pc on the next edge when stall=0 (one-cycle redirect latency).
REQ-023 SHALL, when stall=1, capture the branch/jump target into a pending register, hold pc, and enter PEND.
REQ-024 SHALL, in PEND, overwrite the pending target with any newer branch/jump request (newest wins).
REQ-025 SHALL, in PEND with stall=0 and no new request, load the pending target into pc and return to RUN.
REQ-026 SHALL, in PEND with stall=0 and a new branch/jump request, load the new target (not the pending one) and return to RUN.
REQ-027 SHALL, in RUN with stall=0 and no request, load pc_plus4; with stall=1 and no request, hold pc.
REQ-028 SHALL treat any branch/jump/pending target with bits [1:0] != 0 as misaligned: pc<=TRAP_VECTOR, misaligned=1 for one cycle, bad_addr<=target, state RUN.
REQ-029 SHALL never reject a trap target; trap_target is loaded unchecked.
REQ-030 SHALL increment redirect_cnt once per edge on which pc takes a redirect, trap, or TRAP_VECTOR value, and hold it at 2^CNT_W-1.
REQ-031 SHALL have exactly two states, RUN and PEND, with transitions only as stated in REQ-021 to REQ-028.

Reset
REQ-032 SHALL, while reset=1, set pc=RESET_VECTOR, state=RUN, pending target=0, redirect_pending=0, misaligned=0, bad_addr=0, redirect_cnt=0.
REQ-033 SHALL give reset priority over every other input, including a trap or redirect asserted mid-PEND.
REQ-034 SHALL make the first sequential advance (to RESET_VECTOR+4) on the first edge after reset=0 with stall=0.

Structure
REQ-035 SHALL place the state enum (RUN, PEND) and the default vector constants in shared package pc_pkg.
REQ-036 SHALL implement the saturating counter as sub-module sat_counter (parameter W; inputs clk, reset, inc; output count).

Verification
REQ-037 SHALL cover reset release with stall=0 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC.
REQ-038 SHALL cover branch_valid, branch_target=0x100, with stall=1 for 2 cycles, then stall=0 -> pc held, redirect_pending=1, then pc=0x100 and redirect_cnt=1.
REQ-039 SHALL cover PEND holding 0x100 followed by jump_valid, jump_target=0x200, while stalled, then release -> pc=0x200; 0x100 is never fetched.
REQ-040 SHALL cover trap_valid, trap_target=0x40, with branch_valid and stall=1 in the same cycle -> pc=0x40 next edge and redirect_pending=0.
REQ-041 SHALL cover jump_target=0x102 -> pc=0x80, misaligned pulse of one cycle, bad_addr=0x102.
REQ-042 SHALL cover CNT_W=2 with 5 redirects -> redirect_cnt saturates at 3.
